// File: rtl/edge_extract_pkg.sv
// Shared constants and encodings for the edge-extraction stage and the
// downstream contour stage.
package edge_extract_pkg;

    localparam int WIDTH        = 640;
    localparam int HEIGHT       = 480;
    localparam int ADDR_W       = 19;
    localparam int BIN_W        = 3;
    localparam int CNT_W        = 12;
    localparam int READ_LATENCY = 2;
    localparam int NUM_SLOTS    = 5;

    localparam logic [BIN_W-1:0] EDGE_VALUE = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Read-slot order within one pixel's fetch burst.
    typedef enum logic [2:0] {
        SLOT_CENTRE,
        SLOT_UP,
        SLOT_DOWN,
        SLOT_LEFT,
        SLOT_RIGHT
    } slot_t;

endpackage

// File: rtl/edge_extract_if.sv
// Mask-read / edge-write memory bus between the extractor and its BRAMs.
interface edge_extract_if;
    import edge_extract_pkg::*;

    logic [ADDR_W-1:0] mask_addr;
    logic              mask_data;
    logic [ADDR_W-1:0] edge_addr;
    logic [BIN_W-1:0]  edge_data;
    logic              edge_we;

    modport master (
        output mask_addr, edge_addr, edge_data, edge_we,
        input  mask_data
    );

    modport slave (
        input  mask_addr, edge_addr, edge_data, edge_we,
        output mask_data
    );
endinterface

// File: rtl/raster_counter.sv
// Raster position tracker: x/y plus a linear address kept in step without a
// multiplier, with a flag marking the final pixel of the frame.
module raster_counter
    import edge_extract_pkg::*;
#(
    parameter int W   = WIDTH,
    parameter int H   = HEIGHT,
    parameter int X_W = $clog2(W + 1),
    parameter int Y_W = $clog2(H + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic [ADDR_W-1:0] addr_reg;

    assign last = (x_reg == X_LAST) && (y_reg == Y_LAST);

    // Step one pixel per enable, wrapping x into the next row and the whole
    // frame back to the origin.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            x_reg    <= '0;
            y_reg    <= '0;
            addr_reg <= '0;
        end else if (en) begin
            if (x_reg == X_LAST) begin
                x_reg <= '0;
                y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
            addr_reg <= last ? '0 : addr_reg + 1'b1;
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign addr = addr_reg;
endmodule

// File: rtl/edge_extract.sv
// Raster-scans a 1-bit foreground mask, marks foreground pixels touching
// background or the frame border as edges, and counts them (saturating).
module edge_extract #(
    parameter int WIDTH        = edge_extract_pkg::WIDTH,
    parameter int HEIGHT       = edge_extract_pkg::HEIGHT,
    parameter int READ_LATENCY = edge_extract_pkg::READ_LATENCY,
    parameter logic [edge_extract_pkg::BIN_W-1:0] EDGE_VALUE = edge_extract_pkg::EDGE_VALUE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    edge_extract_if.master                   bus,
    output logic [edge_extract_pkg::CNT_W-1:0] num_pixels,
    output logic                             busy,
    output logic                             done
);
    import edge_extract_pkg::*;

    localparam int X_W = $clog2(WIDTH + 1);
    localparam int Y_W = $clog2(HEIGHT + 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WIDTH);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [3:0]        WAIT_LAST = 4'(READ_LATENCY - 1);

    state_t                 state_reg, state_next;
    slot_t                  slot_reg, slot_next;
    logic [3:0]             wait_reg, wait_next;
    logic                   start_d_reg;
    logic                   start_rise;
    logic                   cnt_clr, cnt_en, cnt_last;
    logic                   issue;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      nb_addr, hold_addr_reg, mask_addr_now;
    logic                   nb_oob;
    logic [READ_LATENCY-1:0] pipe_valid_reg, pipe_valid_next;
    logic [READ_LATENCY-1:0] pipe_force_reg, pipe_force_next;
    logic [NUM_SLOTS-1:0]   sample_reg;
    logic                   edge_hit;
    logic [CNT_W-1:0]       num_reg;

    assign start_rise = start & ~start_d_reg;

    raster_counter #(
        .W   (WIDTH),
        .H   (HEIGHT),
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .x     (x),
        .y     (y),
        .addr  (addr),
        .last  (cnt_last)
    );

    // State, read-slot and latency-wait registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            slot_reg  <= SLOT_CENTRE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state logic: five issue cycles, a fixed latency wait, one write.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        wait_next  = wait_reg;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_next = ST_FETCH;
                    slot_next  = SLOT_CENTRE;
                    cnt_clr    = 1'b1;
                end
            end
            ST_FETCH: begin
                issue = 1'b1;
                if (slot_reg == SLOT_RIGHT) begin
                    state_next = ST_COLLECT;
                    wait_next  = '0;
                end else begin
                    slot_next = slot_t'(slot_reg + 3'd1);
                end
            end
            ST_COLLECT: begin
                if (wait_reg == WAIT_LAST) state_next = ST_WRITE;
                else                       wait_next  = wait_reg + 4'd1;
            end
            ST_WRITE: begin
                cnt_en     = 1'b1;
                slot_next  = SLOT_CENTRE;
                state_next = cnt_last ? ST_DONE : ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Neighbour address select; out-of-frame neighbours re-read the centre
    // so the address never under/overflows, and their data is forced to 0.
    always_comb begin
        nb_addr = addr;
        nb_oob  = 1'b0;
        case (slot_reg)
            SLOT_UP: begin
                nb_oob  = (y == '0);
                nb_addr = nb_oob ? addr : addr - ROW_STEP;
            end
            SLOT_DOWN: begin
                nb_oob  = (y == Y_LAST);
                nb_addr = nb_oob ? addr : addr + ROW_STEP;
            end
            SLOT_LEFT: begin
                nb_oob  = (x == '0);
                nb_addr = nb_oob ? addr : addr - 1'b1;
            end
            SLOT_RIGHT: begin
                nb_oob  = (x == X_LAST);
                nb_addr = nb_oob ? addr : addr + 1'b1;
            end
            default: begin
                nb_oob  = 1'b0;
                nb_addr = addr;
            end
        endcase
    end

    assign mask_addr_now = issue ? nb_addr : hold_addr_reg;

    // Delay line tracking which cycles return read data, and whether that
    // data must be forced to background.
    assign pipe_valid_next[0] = issue;
    assign pipe_force_next[0] = issue & nb_oob;
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_force_next[gi] = pipe_force_reg[gi-1];
    end

    // Start edge detector, address hold, read-return pipeline and samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_d_reg    <= 1'b0;
            hold_addr_reg  <= '0;
            pipe_valid_reg <= '0;
            pipe_force_reg <= '0;
            sample_reg     <= '0;
        end else begin
            start_d_reg    <= start;
            hold_addr_reg  <= mask_addr_now;
            pipe_valid_reg <= pipe_valid_next;
            pipe_force_reg <= pipe_force_next;
            if (pipe_valid_reg[READ_LATENCY-1])
                sample_reg <= {sample_reg[NUM_SLOTS-2:0],
                               bus.mask_data & ~pipe_force_reg[READ_LATENCY-1]};
        end
    end

    // After five samples bit 4 holds the centre, bits 3..0 the neighbours.
    assign edge_hit = sample_reg[NUM_SLOTS-1] & ~(&sample_reg[NUM_SLOTS-2:0]);

    // Saturating edge-pixel counter, cleared on every accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr)
            num_reg <= '0;
        else if (state_reg == ST_WRITE && edge_hit && num_reg != CNT_MAX)
            num_reg <= num_reg + 1'b1;
    end

    assign bus.mask_addr = mask_addr_now;
    assign bus.edge_we   = (state_reg == ST_WRITE);
    assign bus.edge_addr = addr;
    assign bus.edge_data = (state_reg == ST_WRITE && edge_hit) ? EDGE_VALUE : '0;
    assign num_pixels    = num_reg;
    assign busy          = (state_reg == ST_FETCH) || (state_reg == ST_COLLECT) ||
                           (state_reg == ST_WRITE);
    assign done          = (state_reg == ST_DONE);
endmodule

// File: tb/tb_edge_extract.sv
// Directed bench: a small-frame instance for write-by-write scoreboarding and
// a larger-frame instance for counter saturation, run side by side.
module tb_edge_extract;
    import edge_extract_pkg::*;

    localparam int SW = 24, SH = 20, SN = SW * SH;
    localparam int BW = 64, BH = 82, BN = BW * BH;

    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, rst_b_n, start_s, start_b;
    logic [CNT_W-1:0]  num_s, num_b;
    logic              busy_s, done_s, busy_b, done_b;

    edge_extract_if bus_s ();
    edge_extract_if bus_b ();

    edge_extract #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bus_s),
        .num_pixels(num_s), .busy(busy_s), .done(done_s)
    );

    edge_extract #(.WIDTH(BW), .HEIGHT(BH)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .bus(bus_b),
        .num_pixels(num_b), .busy(busy_b), .done(done_b)
    );

    bit mask_s [SN];
    bit mask_b [BN];

    // Two-cycle pipelined mask BRAM models.
    logic [ADDR_W-1:0] ra_s, ra_b;
    logic              rd_s, rd_b;
    always @(posedge clk) begin
        ra_s <= bus_s.mask_addr;
        rd_s <= (int'(ra_s) < SN) ? mask_s[int'(ra_s)] : 1'b0;
        ra_b <= bus_b.mask_addr;
        rd_b <= (int'(ra_b) < BN) ? mask_b[int'(ra_b)] : 1'b0;
    end
    assign bus_s.mask_data = rd_s;
    assign bus_b.mask_data = rd_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t q_s[$];
    int  total = 0, bad = 0;
    int  start_cyc, start_cyc_b;
    int  wr_idx_s = 0, wr_cnt_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Small-frame write monitor: pop the expected write and compare.
    always @(negedge clk) begin
        if (bus_s.edge_we === 1'b1) begin
            wr_t e;
            check("write_expected", q_s.size() > 0, 1);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check("wr_addr", bus_s.edge_addr, e.addr);
                check("wr_data", bus_s.edge_data, e.data);
                check("wr_cycle", cyc - start_cyc, e.when);
            end
            $display("write addr=%0d data=%0d t=%0d", bus_s.edge_addr, bus_s.edge_data,
                     cyc - start_cyc);
            wr_idx_s++;
        end
        if (bus_b.edge_we === 1'b1) wr_cnt_b++;
    end

    function automatic bit px_s(int x, int y);
        if (x < 0 || y < 0 || x >= SW || y >= SH) return 1'b0;
        return mask_s[y * SW + x];
    endfunction

    function automatic bit px_b(int x, int y);
        if (x < 0 || y < 0 || x >= BW || y >= BH) return 1'b0;
        return mask_b[y * BW + x];
    endfunction

    task automatic set_mask_s(input int kind);
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                case (kind)
                    1:       mask_s[y*SW+x] = (x == 10 && y == 10);
                    2:       mask_s[y*SW+x] = (x >= 5 && x <= 14 && y >= 5 && y <= 14);
                    3:       mask_s[y*SW+x] = 1'b1;
                    4:       mask_s[y*SW+x] = ((x + y) % 2 == 0);
                    default: mask_s[y*SW+x] = 1'b0;
                endcase
    endtask

    task automatic load_s();
        wr_t e;
        q_s.delete();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                e.addr = y * SW + x;
                e.data = (px_s(x, y) && !(px_s(x, y-1) && px_s(x, y+1) &&
                                          px_s(x-1, y) && px_s(x+1, y))) ? 1 : 0;
                e.when = 8 * (e.addr + 1);
                q_s.push_back(e);
            end
    endtask

    task automatic wait_done_s(input string name);
        int n = 0;
        while (done_s !== 1'b1 && n < 8 * SN + 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, done_s, 1);
        check({name, "_done_cycle"}, cyc - start_cyc, 8 * SN + 1);
    endtask

    task automatic pass_s(input string name, input int exp_num, input bit hold);
        load_s();
        @(negedge clk);
        start_s   = 1'b1;
        start_cyc = cyc;
        wr_idx_s  = 0;
        @(negedge clk);
        if (!hold) start_s = 1'b0;
        check({name, "_busy_on_start"}, busy_s, 1);
        check({name, "_done_cleared"}, done_s, 0);
        check({name, "_num_cleared"}, num_s, 0);
        wait_done_s(name);
        check({name, "_num_pixels"}, num_s, exp_num);
        check({name, "_busy_after"}, busy_s, 0);
        check({name, "_queue_left"}, q_s.size(), 0);
        if (hold) begin
            repeat (40) @(negedge clk);
            check({name, "_hold_done"}, done_s, 1);
            check({name, "_hold_busy"}, busy_s, 0);
            start_s = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, busy_s, 0);
        check({name, "_done"}, done_s, 0);
        check({name, "_num"}, num_s, 0);
        check({name, "_we"}, bus_s.edge_we, 0);
        check({name, "_edge_addr"}, bus_s.edge_addr, 0);
        check({name, "_edge_data"}, bus_s.edge_data, 0);
        check({name, "_mask_addr"}, bus_s.mask_addr, 0);
    endtask

    initial begin
        int exp_b;
        int n;
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n   = 1'b1;
        rst_b_n = 1'b1;

        // Large frame: background where (x+2y)%5==0, so every foreground
        // pixel has a background neighbour and the count exceeds 4095.
        exp_b = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                mask_b[y*BW+x] = ((x + 2*y) % 5 != 0);
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                if (px_b(x, y) && !(px_b(x, y-1) && px_b(x, y+1) &&
                                    px_b(x-1, y) && px_b(x+1, y)))
                    exp_b++;
        if (exp_b > 4095) exp_b = 4095;
        @(negedge clk);
        start_b     = 1'b1;
        start_cyc_b = cyc;
        @(negedge clk);
        start_b = 1'b0;

        set_mask_s(0); pass_s("zero", 0, 1'b0);
        set_mask_s(1); pass_s("single", 1, 1'b0);
        set_mask_s(2); pass_s("square", 36, 1'b0);
        set_mask_s(3); pass_s("ones", 2*SW + 2*(SH-2), 1'b0);
        set_mask_s(4); pass_s("checker", SN/2, 1'b0);

        // Mid-pass start is ignored; mid-pass reset returns to idle.
        load_s();
        @(negedge clk);
        start_s   = 1'b1;
        start_cyc = cyc;
        wr_idx_s  = 0;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (wr_idx_s < 200 && n < 8 * SN) begin @(negedge clk); n++; end
        check("restart_reach_200", wr_idx_s >= 200, 1);
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        check("restart_still_busy", busy_s, 1);
        n = 0;
        while (wr_idx_s < 400 && n < 8 * SN) begin @(negedge clk); n++; end
        check("restart_reach_400", wr_idx_s >= 400, 1);
        @(negedge clk);
        rst_n = 1'b0;
        q_s.delete();
        @(negedge clk);
        check_idle_outputs("midreset");
        rst_n = 1'b1;

        // Start pulse coinciding with reset is discarded.
        @(negedge clk); rst_n = 1'b0; start_s = 1'b1;
        @(negedge clk); rst_n = 1'b1; start_s = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_start_busy", busy_s, 0);
        check("rst_start_done", done_s, 0);

        set_mask_s(3); pass_s("after_reset_hold", 2*SW + 2*(SH-2), 1'b1);

        n = 0;
        while (done_b !== 1'b1 && n < 8 * BN + 100) begin @(negedge clk); n++; end
        check("sat_done", done_b, 1);
        check("sat_done_cycle", cyc - start_cyc_b, 8 * BN + 1);
        check("sat_num_pixels", num_b, exp_b);
        check("sat_writes", wr_cnt_b, BN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_extract.md
# edge_extract

Raster-scans a 640×480 1-bit foreground mask BRAM and writes a 3-bit edge map BRAM: 3'b001 for boundary pixels, 3'b000 elsewhere. It also counts the edge pixels. It sits directly upstream of the contour/bin-colouring stage:
- `edge_addr`/`edge_data` feed that stage's edge BRAM.
- `num_pixels` feeds its pixel count.
- `done` drives its active-high `start` level.

## Interface
- `WIDTH`, 640, frame width in pixels
- `HEIGHT`, 480, frame height in pixels
- `READ_LATENCY`, 2, mask BRAM read latency in cycles (fixed, pipelined)
- `EDGE_VALUE`, 3'b001, value written for an edge pixel
- `clk` in 1: system clock
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: request a pass; the rising edge is detected internally
- `mask_addr` out 19: mask BRAM read address, y*WIDTH+x
- `mask_data` in 1: mask BRAM read data, 1 = foreground
- `edge_addr` out 19: edge BRAM write address
- `edge_data` out 3: edge BRAM write data
- `edge_we` out 1: edge BRAM write enable, one cycle per pixel
- `num_pixels` out 12: saturating edge-pixel count; valid while `done` is high
- `busy` out 1: pass in progress
- `done` out 1: level; pass complete

## Operation
- Reset values: all outputs are 0, the state is IDLE, and the start edge detector is cleared.
- States: IDLE → FETCH → COLLECT → WRITE → (FETCH | DONE); DONE → FETCH on a new start.
- Start acceptance:
  - A start rising edge is accepted in IDLE or DONE.
  - On acceptance: `done` clears, `num_pixels` clears, x=y=addr=0, `busy` sets.
  - A start edge during `busy` is ignored.
  - A held-high `start` does not retrigger.
- Per pixel (x,y), in FETCH, five read slots are issued on consecutive cycles, in this order: centre, up, down, left, right.
  - A neighbour outside the frame issues the centre address as a dummy read, and its result is forced to background.
- COLLECT waits for the last slot's data.
  - Slot k data is sampled exactly READ_LATENCY cycles after slot k was issued.
- Edge rule: centre = 1 AND (any 4-neighbour = 0 OR any 4-neighbour is out of frame).
  - Consequence: foreground pixels on the frame border are always edges.
- WRITE, one cycle:
  - `edge_we`=1, `edge_addr`=addr, `edge_data` = EDGE_VALUE if edge, else 3'b000.
  - If edge and `num_pixels` < 4095, increment `num_pixels`; at 4095 it saturates.
- Advance after WRITE:
  - x wraps at WIDTH-1 to 0 and y increments.
  - addr increments by 1, computed incrementally with no multiplier.
  - After pixel (WIDTH-1, HEIGHT-1), go to DONE.
- DONE: `busy`=0, `done`=1, held until reset or an accepted start.
- `edge_we` is 0 in every state except WRITE. `mask_addr` holds its last value when no read is being issued.

## Timing
- Per pixel: 5 issue cycles + READ_LATENCY + 1 write cycle = 8 cycles at READ_LATENCY=2.
- Accepted start at cycle 0 (the start edge is sampled at the end of cycle 0):
  - The first centre read is issued at cycle 1.
  - The first write is at cycle 8.
  - The write for pixel n is at cycle 8(n+1).
- Full pass: the last write is at cycle 8·307200 = 2,457,600; `done` rises at cycle 2,457,601.
- `rst_n` low mid-pass:
  - The next edge gives IDLE with all outputs 0, and `edge_we` is 0 from that edge on.
  - Partially written edge-map contents are left as-is.
- `rst_n` low and a start edge in the same cycle: reset wins, and the start edge is discarded.
- Address width: 19 bits covers 307,199. The dummy-address substitution guarantees no underflow or overflow on neighbour addresses (addr±1, addr±WIDTH).

## Structure
- Shared package: WIDTH, HEIGHT, ADDR_W=19, BIN_W=3, EDGE_VALUE, and the state encoding. The downstream contour stage uses the same constants.
- Sub-module: `raster_counter`, which holds x/y/addr with enable, clear, wrap and a last-pixel flag. It is reusable by the display-readout stage.
- The top level holds the FSM, the neighbour-address mux with out-of-frame forcing, a 5-bit sample shift register and the saturating counter.

## Test plan
- All-zero mask:
  - 307,200 writes, all 3'b000, at addresses 0..307199 in order.
  - `num_pixels`=0; `done` rises 2,457,601 cycles after the start edge.
- Single foreground pixel at (10,10), addr 6410: exactly one write of 3'b001, at 6410; `num_pixels`=1.
- Filled square x,y ∈ 100..109: 36 writes of 3'b001 on the perimeter; the 64 interior pixels written 3'b000; `num_pixels`=36.
- All-ones mask: only frame-border pixels are edges, 2·640 + 2·478 = 2236, including addr 0 and 307199; `num_pixels`=2236.
- Checkerboard mask: 153,600 edge pixels; `num_pixels` saturates at 4095.
- Restart and reset:
  - A start edge at pixel 500 is ignored.
  - `rst_n` low at pixel 1000 gives all outputs 0 the next cycle.
  - A new start then completes a full pass with correct results.
  - Holding `start` high after `done` does not restart.
